mul_issue_ctrl: RTL

//  Requester side of the M-extension multiplier valid/ready interface. Takes MUL/MULH/MULHSU/MULHU

---
 rtl/mul_issue_ctrl_if.sv | 32 +++
 rtl/mul_issue_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if
//   Valid/ready link between the multiplier requester (mul_issue_ctrl) and
//   the M-extension multiplier. The request carries operands and op select,
//   the response carries the 32-bit result.
//
//   mul_a, mul_b   32  operands              (master -> slave)
//   mul_op_sel     2   MUL/MULH/MULHSU/MULHU (master -> slave)
//   mul_in_valid   1   request valid         (master -> slave)
//   mul_in_ready   1   request accepted      (slave -> master)
//   mul_out_valid  1   result valid          (slave -> master)
//   mul_out_ready  1   result consumed       (master -> slave)
//   mul_result     32  result                (slave -> master)
interface mul_issue_ctrl_if;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [1:0]  mul_op_sel;
    logic        mul_in_valid;
    logic        mul_in_ready;
    logic        mul_out_valid;
    logic        mul_out_ready;
    logic [31:0] mul_result;

    modport master (
        output mul_a, mul_b, mul_op_sel, mul_in_valid, mul_out_ready,
        input  mul_in_ready, mul_out_valid, mul_result
    );

    modport slave (
        input  mul_a, mul_b, mul_op_sel, mul_in_valid, mul_out_ready,
        output mul_in_ready, mul_out_valid, mul_result
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Requester side of the M-extension multiplier. Accepts MUL/MULH/MULHSU/MULHU
//   from EX, stalls the pipeline, issues one request over mul_if, consumes the
//   result and returns it as a one-cycle writeback pulse.
//
//   Optional watchdog: define MULDIV_TIMEOUT_EN to bound the time spent waiting
//   for a result (TIMEOUT_CYCLES); expiry pulses err_timeout_o and returns to
//   idle without a writeback. Without the macro there is no counter and
//   err_timeout_o is tied low.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   ex_valid_i          EX holds an M-type instruction
//   ex_op_i[2:0]        funct3; 1xx (divide) is ignored here
//   ex_rs1_i, ex_rs2_i  operands
//   ex_rd_i             destination register (x0 is ignored)
//   flush_i             kills the in-flight instruction
//   stall_o             hold EX and earlier stages
//   mul_if              multiplier request/response (master side)
//   wb_valid_o          one-cycle writeback pulse
//   wb_rd_o, wb_data_o  writeback register/data, held after the pulse
//   err_timeout_o       one-cycle pulse on watchdog expiry
module mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid_i,
    input  logic [2:0]           ex_op_i,
    input  logic [31:0]          ex_rs1_i,
    input  logic [31:0]          ex_rs2_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    mul_issue_ctrl_if.master     mul_if,
    output logic                 wb_valid_o,
    output logic [4:0]           wb_rd_o,
    output logic [31:0]          wb_data_o,
    output logic                 err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_WB
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
    } req_t;

    state_e      state_q;
    req_t        req_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        accept;

    // Divide ops and writes to x0 never reach the multiplier.
    assign accept = (state_q == S_IDLE) && ex_valid_i && !ex_op_i[2] &&
                    (ex_rd_i != 5'd0) && !flush_i;

`ifdef MULDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;
    logic             to_expire;

    // Counter holds the number of completed WAIT/DRAIN cycles, so the
    // TIMEOUT_CYCLES-th cycle is the one that sees TIMEOUT_CYCLES-1.
    assign to_expire     = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout_o = err_q;
`else
    // Only the watchdog build needs the timeout length.
    logic unused_cfg;
    assign unused_cfg    = (TIMEOUT_CYCLES != 0);
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
`ifdef MULDIV_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_q   <= '{a: ex_rs1_i, b: ex_rs2_i, op: ex_op_i[1:0], rd: ex_rd_i};
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Flush beats a simultaneous ready: in_valid is already low.
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (mul_if.mul_in_ready) begin
                        state_q <= S_WAIT;
`ifdef MULDIV_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mul_if.mul_out_valid) begin
                        if (!flush_i) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= req_q.rd;
                            wb_data_q  <= mul_if.mul_result;
                            state_q    <= S_WB;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (flush_i) begin
                        // Multiplier still owes us a result; swallow it in DRAIN.
                        state_q <= S_DRAIN;
`ifdef MULDIV_TIMEOUT_EN
                        to_cnt_q <= '0;
                    end else if (to_expire) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_DRAIN: begin
                    if (mul_if.mul_out_valid) begin
                        state_q <= S_IDLE;
`ifdef MULDIV_TIMEOUT_EN
                    end else if (to_expire) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Operands/op come straight from the latched request so they stay stable
    // until the result handshake; the multiplier samples op_sel late.
    assign mul_if.mul_a         = req_q.a;
    assign mul_if.mul_b         = req_q.b;
    assign mul_if.mul_op_sel    = req_q.op;
    assign mul_if.mul_in_valid  = (state_q == S_ISSUE) && !flush_i;
    assign mul_if.mul_out_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);

    // In DRAIN a new multiply in EX must wait until the old result is gone.
    assign stall_o = accept || (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                     ((state_q == S_DRAIN) && ex_valid_i && !ex_op_i[2]);

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

endmodule
